// File: rtl/branch_config_sequencer.sv
// branch_config_sequencer: FIFO-buffered branch-table writer committing each request in its thread's slot; BRANCH_CONFIG_CLEAR_EN adds a post-reset clear sweep
module branch_config_sequencer #(
    parameter int unsigned THREAD_COUNT      = 8,
    parameter int unsigned THREAD_ADDR_WIDTH = 3,
    parameter int unsigned INITIAL_THREAD    = 0,
    parameter int unsigned ENTRY_COUNT       = 4,
    parameter int unsigned ENTRY_ADDR_WIDTH  = 2,
    parameter int unsigned PC_WIDTH          = 10,
    parameter int unsigned CONDITION_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned FIFO_ADDR_WIDTH   = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [THREAD_ADDR_WIDTH-1:0] in_thread_i,
    input  logic [ENTRY_ADDR_WIDTH-1:0]  in_entry_i,
    input  logic [2:0]                   in_mask_i,
    input  logic [PC_WIDTH-1:0]          in_origin_i,
    input  logic [PC_WIDTH-1:0]          in_destination_i,
    input  logic [CONDITION_WIDTH-1:0]   in_condition_i,
    output logic [ENTRY_COUNT-1:0]       wren_BO_o,
    output logic [ENTRY_COUNT-1:0]       wren_BD_o,
    output logic [ENTRY_COUNT-1:0]       wren_BC_o,
    output logic [THREAD_ADDR_WIDTH-1:0] write_addr_o,
    output logic [PC_WIDTH-1:0]          write_data_BO_o,
    output logic [PC_WIDTH-1:0]          write_data_BD_o,
    output logic [CONDITION_WIDTH-1:0]   write_data_BC_o,
    output logic [THREAD_ADDR_WIDTH-1:0] slot_thread_o,
    output logic                         busy_o,
    output logic                         error_o
);
    typedef logic [THREAD_ADDR_WIDTH-1:0] thr_t;
    typedef logic [ENTRY_COUNT-1:0] ent_t;
    typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_ADDR_WIDTH:0] cnt_t;
    typedef struct packed {
        thr_t                        thread;
        logic [ENTRY_ADDR_WIDTH-1:0] entry;
        logic [2:0]                  mask;
        logic [PC_WIDTH-1:0]         origin;
        logic [PC_WIDTH-1:0]         destination;
        logic [CONDITION_WIDTH-1:0]  condition;
    } req_t;
    typedef enum logic {IDLE, CLEAR} state_t;
`ifdef BRANCH_CONFIG_CLEAR_EN
    localparam state_t START = CLEAR;
`else
    localparam state_t START = IDLE;
`endif

    req_t                       fifo_q [FIFO_DEPTH];
    req_t                       head;
    ptr_t                       wr_ptr_q, rd_ptr_q;
    cnt_t                       count_q, count_d;
    state_t                     state_q, state_d;
    thr_t                       clr_q, clr_d, slot_q, slot_d, addr_q, addr_d;
    ent_t                       wren_bo_q, wren_bo_d, wren_bd_q, wren_bd_d, wren_bc_q, wren_bc_d, onehot;
    logic [PC_WIDTH-1:0]        data_bo_q, data_bo_d, data_bd_q, data_bd_d;
    logic [CONDITION_WIDTH-1:0] data_bc_q, data_bc_d;
    logic                       error_q, error_d, full, empty, push, pop, bad, hit;

    assign head       = fifo_q[rd_ptr_q];
    assign bad        = 32'(head.thread) >= THREAD_COUNT || 32'(head.entry) >= ENTRY_COUNT;
    assign hit        = head.thread == slot_q;
    assign onehot     = ent_t'(1) << head.entry;
    assign full       = count_q == cnt_t'(FIFO_DEPTH);
    assign empty      = count_q == '0;
    assign in_ready_o = !reset_i && !full && state_q == IDLE;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = !empty && state_q == IDLE && (bad || hit);
    assign count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
    assign busy_o     = !empty || state_q == CLEAR;

    assign wren_BO_o       = wren_bo_q;
    assign wren_BD_o       = wren_bd_q;
    assign wren_BC_o       = wren_bc_q;
    assign write_addr_o    = addr_q;
    assign write_data_BO_o = data_bo_q;
    assign write_data_BD_o = data_bd_q;
    assign write_data_BC_o = data_bc_q;
    assign slot_thread_o   = slot_q;
    assign error_o         = error_q;

    // Next state: slot rotation, clear sweep, and the one-cycle commit strobes for a popped head
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        slot_d    = slot_q == thr_t'(THREAD_COUNT - 1) ? '0 : slot_q + 1'b1;
        wren_bo_d = '0;
        wren_bd_d = '0;
        wren_bc_d = '0;
        addr_d    = addr_q;
        data_bo_d = data_bo_q;
        data_bd_d = data_bd_q;
        data_bc_d = data_bc_q;
        error_d   = error_q | (pop && bad);
        if (state_q == CLEAR) begin
            wren_bo_d = '1;
            wren_bd_d = '1;
            wren_bc_d = '1;
            addr_d    = clr_q;
            data_bo_d = '0;
            data_bd_d = '0;
            data_bc_d = '0;
            clr_d     = clr_q + 1'b1;
            state_d   = clr_q == thr_t'(THREAD_COUNT - 1) ? IDLE : CLEAR;
        end else if (pop && !bad && |head.mask) begin
            wren_bo_d = head.mask[0] ? onehot : '0;
            wren_bd_d = head.mask[1] ? onehot : '0;
            wren_bc_d = head.mask[2] ? onehot : '0;
            addr_d    = head.thread;
            data_bo_d = head.origin;
            data_bd_d = head.destination;
            data_bc_d = head.condition;
        end
    end

    // Control and output registers; reset also discards anything still queued
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= START;
            clr_q     <= '0;
            slot_q    <= thr_t'(INITIAL_THREAD);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wren_bo_q <= '0;
            wren_bd_q <= '0;
            wren_bc_q <= '0;
            addr_q    <= '0;
            data_bo_q <= '0;
            data_bd_q <= '0;
            data_bc_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_q + ptr_t'(push);
            rd_ptr_q  <= rd_ptr_q + ptr_t'(pop);
            count_q   <= count_d;
            wren_bo_q <= wren_bo_d;
            wren_bd_q <= wren_bd_d;
            wren_bc_q <= wren_bc_d;
            addr_q    <= addr_d;
            data_bo_q <= data_bo_d;
            data_bd_q <= data_bd_d;
            data_bc_q <= data_bc_d;
            error_q   <= error_d;
        end
    end

    // Request storage; contents are don't-care until pointed at by a valid count
    always_ff @(posedge clock_i) begin
        if (push) fifo_q[wr_ptr_q] <= '{in_thread_i, in_entry_i, in_mask_i, in_origin_i, in_destination_i, in_condition_i};
    end
endmodule

// File: tb/tb_branch_config_sequencer.sv
// tb_branch_config_sequencer: directed and random checks of branch_config_sequencer against a queue-based reference model
module tb_branch_config_sequencer;
    localparam int TC = 8, TAW = 4, EC = 3, EAW = 2, PW = 10, CW = 4, FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, v, rdy, busy, err;
    logic [TAW-1:0] th, waddr, slot;
    logic [EAW-1:0] en;
    logic [2:0] mk;
    logic [PW-1:0] o, d, dbo, dbd;
    logic [CW-1:0] c, dbc;
    logic [EC-1:0] wbo, wbd, wbc;

    branch_config_sequencer #(
        .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW), .INITIAL_THREAD(0), .ENTRY_COUNT(EC),
        .ENTRY_ADDR_WIDTH(EAW), .PC_WIDTH(PW), .CONDITION_WIDTH(CW), .FIFO_DEPTH(FD), .FIFO_ADDR_WIDTH(2)
    ) dut (
        .clock_i(clk), .reset_i(rst), .in_valid_i(v), .in_ready_o(rdy), .in_thread_i(th), .in_entry_i(en),
        .in_mask_i(mk), .in_origin_i(o), .in_destination_i(d), .in_condition_i(c),
        .wren_BO_o(wbo), .wren_BD_o(wbd), .wren_BC_o(wbc), .write_addr_o(waddr),
        .write_data_BO_o(dbo), .write_data_BD_o(dbd), .write_data_BC_o(dbc),
        .slot_thread_o(slot), .busy_o(busy), .error_o(err)
    );

    typedef struct {int th, en, mk, o, d, c;} req_t;
    req_t q[$];
    int m_slot, m_err, m_wbo, m_wbd, m_wbc, m_addr, m_bo, m_bd, m_bc;
    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_slot = 0; m_err = 0; m_wbo = 0; m_wbd = 0; m_wbc = 0;
        m_addr = 0; m_bo = 0; m_bd = 0; m_bc = 0;
    endtask

    task automatic step(input bit vi, input int ti, input int ei, input int mi, input int oi, input int di, input int ci, output bit acc);
        req_t h;
        int r;
        v = vi; th = TAW'(ti); en = EAW'(ei); mk = 3'(mi); o = PW'(oi); d = PW'(di); c = CW'(ci);
        #1;
        r = q.size() < FD ? 1 : 0;
        chk("in_ready", rdy, r);
        chk("busy", busy, q.size() != 0 ? 1 : 0);
        chk("slot_thread", slot, m_slot);
        chk("error", err, m_err);
        chk("wren_BO", wbo, m_wbo);
        chk("wren_BD", wbd, m_wbd);
        chk("wren_BC", wbc, m_wbc);
        chk("write_addr", waddr, m_addr);
        chk("data_BO", dbo, m_bo);
        chk("data_BD", dbd, m_bd);
        chk("data_BC", dbc, m_bc);
        m_wbo = 0; m_wbd = 0; m_wbc = 0;
        if (q.size() > 0) begin
            h = q[0];
            if (h.th >= TC || h.en >= EC) begin
                q.delete(0);
                m_err = 1;
            end else if (h.th == m_slot) begin
                q.delete(0);
                if (h.mk != 0) begin
                    m_wbo = (h.mk & 1) != 0 ? 1 << h.en : 0;
                    m_wbd = (h.mk & 2) != 0 ? 1 << h.en : 0;
                    m_wbc = (h.mk & 4) != 0 ? 1 << h.en : 0;
                    m_addr = h.th; m_bo = h.o; m_bd = h.d; m_bc = h.c;
                end
            end
        end
        acc = vi && r == 1;
        if (acc) q.push_back('{ti, ei, mi, oi, di, ci});
        m_slot = (m_slot + 1) % TC;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic push(input int ti, input int ei, input int mi, input int oi, input int di, input int ci);
        bit a = 0;
        for (int k = 0; k < 32 && !a; k++) step(1, ti, ei, mi, oi, di, ci, a);
        chk("push_accepted", a, 1);
    endtask

    task automatic wait_slot(input int s);
        for (int k = 0; k < TC && m_slot != s; k++) idle(1);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && q.size() != 0; k++) idle(1);
        chk("drain_empty", q.size(), 0);
        idle(2);
    endtask

    task automatic rand_run(input int n, input int tmax, input int emax);
        bit a;
        repeat (n) step($urandom_range(0, 1), $urandom_range(0, tmax), $urandom_range(0, emax), $urandom_range(0, 7),
                        $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 15), a);
    endtask

    task automatic do_reset(input int n);
        rst = 1; v = 1; th = 1; en = 0; mk = 3'b111;
        repeat (n) begin
            #1;
            chk("in_ready_in_reset", rdy, 0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 0; v = 0;
        model_reset();
`ifdef BRANCH_CONFIG_CLEAR_EN
        for (int i = 0; i < TC; i++) begin
            #1;
            chk("clr_in_ready", rdy, 0);
            chk("clr_busy", busy, 1);
            chk("clr_wren_BO", wbo, i == 0 ? 0 : (1 << EC) - 1);
            chk("clr_wren_BD", wbd, i == 0 ? 0 : (1 << EC) - 1);
            chk("clr_wren_BC", wbc, i == 0 ? 0 : (1 << EC) - 1);
            chk("clr_addr", waddr, i == 0 ? 0 : i - 1);
            chk("clr_data", {dbo, dbd, dbc}, 0);
            @(posedge clk);
            @(negedge clk);
        end
        m_wbo = (1 << EC) - 1; m_wbd = m_wbo; m_wbc = m_wbo; m_addr = TC - 1;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1; v = 0; th = 0; en = 0; mk = 0; o = 0; d = 0; c = 0;
        @(negedge clk);
        do_reset(2);
        push(5, 2, 7, 'h010, 'h020, 3);
        idle(8);
        wait_slot(2);
        for (int i = 0; i < 5; i++) push(1, i % EC, 7, 'h100 + i, 'h200 + i, i);
        drain();
        wait_slot(0);
        push(3, 0, 1, 'h0aa, 'h0bb, 5);
        wait_slot(3);
        push(3, 1, 6, 'h0cc, 'h0dd, 6);
        drain();
        rand_run(200, TC - 1, EC - 1);
        drain();
        push(9, 1, 7, 'h3ff, 'h3fe, 15);
        push(4, 0, 7, 'h123, 'h321, 9);
        drain();
        push(2, 3, 7, 'h111, 'h222, 1);
        push(6, 1, 0, 'h055, 'h066, 2);
        push(7, 2, 5, 'h077, 'h088, 4);
        drain();
        rand_run(200, 15, 3);
        drain();
        do_reset(1);
        idle(3);
        push((m_slot + 5) % TC, 0, 7, 1, 2, 3);
        push((m_slot + 4) % TC, 1, 7, 4, 5, 6);
        push((m_slot + 3) % TC, 2, 7, 7, 8, 9);
        do_reset(1);
        idle(12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
